// File: rtl/approx_mult_pkg.sv
// Shared constants and address helper for the approximate multiplier datapath.
// Memory map: operand pairs first, then one result word per pair.
package approx_mult_pkg;

    localparam int DATA_W  = 16;
    localparam int MULT_W  = 8;
    localparam int CNT_W   = 5;
    localparam int N_PAIRS = 4;
    localparam int ADDR_W  = 4;

    localparam int A_BASE   = 0;
    localparam int RES_BASE = 2 * N_PAIRS;

    // Address select with priority SA > SB > write > 0.
    function automatic int unsigned pair_addr(
        input logic        sa,
        input logic        sb,
        input logic        wr,
        input int unsigned pc,
        input int unsigned n_pairs
    );
        if (sa) begin
            return A_BASE + 2 * pc;
        end else if (sb) begin
            return A_BASE + 2 * pc + 1;
        end else if (wr) begin
            return 2 * n_pairs + pc;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/approx_mult_datapath_norm_shift_reg.sv
// Operand register: loads from memory, shifts left towards its leading one.
// Exposes only the top bits used by the multiplier plus a normalised flag.
module norm_shift_reg #(
    parameter int W = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [M-1:0] top_bits,
    output logic         done
);

    logic [W-1:0] q;

    // Load has priority over shift; shift inserts a zero at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    // A zero operand counts as normalised so it never needs shifting.
    assign done     = q[W-1] | (q == '0);
    assign top_bits = q[W-1 -: M];

endmodule

// File: rtl/approx_mult_datapath.sv
// Truncated-multiplier datapath: operand normalisation, top-bit multiply,
// result denormalisation, pair/shift counters and memory address mux.
module approx_mult_datapath
    import approx_mult_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int MW = MULT_W,
    parameter int CW = CNT_W,
    parameter int NP = N_PAIRS,
    parameter int AW = ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rst3,
    input  logic            cnt3,
    input  logic            rst5,
    input  logic            read,
    input  logic            write,
    input  logic            SA,
    input  logic            SB,
    input  logic            loadA,
    input  logic            loadB,
    input  logic            ShlA,
    input  logic            ShlB,
    input  logic            cntU,
    input  logic            cntD,
    input  logic            loadOut,
    input  logic            ShrOut,
    input  logic [DW-1:0]   mem_rd_data,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_rd_en,
    output logic            mem_wr_en,
    output logic [2*DW-1:0] mem_wr_data,
    output logic            DoneA,
    output logic            DoneB,
    output logic            down_done,
    output logic            Co3
);

    localparam int PC_W  = $clog2(NP + 1);
    localparam int LOW_Z = 2 * DW - 2 * MW;
    localparam logic [CW-1:0]   CNT_MAX = CW'(2 * DW - 2);
    localparam logic [PC_W-1:0] PC_MAX  = PC_W'(NP);

    logic [MW-1:0]   a_top;
    logic [MW-1:0]   b_top;
    logic [CW-1:0]   shift_cnt;
    logic [PC_W-1:0] pair_cnt;
    logic [2*DW-1:0] res;
    logic [2*MW-1:0] prod;
    logic [2*DW-1:0] prod_ext;

    norm_shift_reg #(
        .W (DW),
        .M (MW)
    ) u_reg_a (
        .clk      (clk),
        .rst      (rst),
        .load     (loadA),
        .shift    (ShlA),
        .din      (mem_rd_data),
        .top_bits (a_top),
        .done     (DoneA)
    );

    norm_shift_reg #(
        .W (DW),
        .M (MW)
    ) u_reg_b (
        .clk      (clk),
        .rst      (rst),
        .load     (loadB),
        .shift    (ShlB),
        .din      (mem_rd_data),
        .top_bits (b_top),
        .done     (DoneB)
    );

    // Truncated product re-aligned to the top of the result word.
    always_comb begin
        prod     = a_top * b_top;
        prod_ext = (2 * DW)'(prod) << LOW_Z;
    end

    // Shift counter: clear > up (saturating) > down (stops at zero).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_cnt <= '0;
        end else if (rst5) begin
            shift_cnt <= '0;
        end else if (cntU) begin
            if (shift_cnt != CNT_MAX) begin
                shift_cnt <= shift_cnt + CW'(1);
            end
        end else if (cntD) begin
            if (shift_cnt != '0) begin
                shift_cnt <= shift_cnt - CW'(1);
            end
        end
    end

    // Pair counter: clear > saturating increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt <= '0;
        end else if (rst3) begin
            pair_cnt <= '0;
        end else if (cnt3) begin
            if (pair_cnt != PC_MAX) begin
                pair_cnt <= pair_cnt + PC_W'(1);
            end
        end
    end

    // Result register: capture product, or denormalise by logical right shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= '0;
        end else if (loadOut) begin
            res <= prod_ext;
        end else if (ShrOut) begin
            res <= res >> 1;
        end
    end

    // Memory address selection from the current pair index.
    always_comb begin
        mem_addr = AW'(pair_addr(SA, SB, write,
                                 int'(pair_cnt), NP));
    end

    assign mem_rd_en   = read;
    assign mem_wr_en   = write;
    assign mem_wr_data = res;
    assign down_done   = (shift_cnt == '0);
    assign Co3         = (pair_cnt == PC_MAX);

endmodule

// File: tb/tb_approx_mult_datapath.sv
// Directed self-checking bench for approx_mult_datapath.
// Drives FSM strobes by hand against a small synchronous memory model.
module tb_approx_mult_datapath;

    logic        clk;
    logic        rst;
    logic        rst3, cnt3, rst5, read, write, SA, SB;
    logic        loadA, loadB, ShlA, ShlB, cntU, cntD;
    logic        loadOut, ShrOut;
    logic [15:0] mem_rd_data;
    logic [3:0]  mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        DoneA, DoneB, down_done, Co3;

    logic [31:0] mem [16];

    int errors = 0;
    int checks = 0;
    int n;

    approx_mult_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .rst3        (rst3),
        .cnt3        (cnt3),
        .rst5        (rst5),
        .read        (read),
        .write       (write),
        .SA          (SA),
        .SB          (SB),
        .loadA       (loadA),
        .loadB       (loadB),
        .ShlA        (ShlA),
        .ShlB        (ShlB),
        .cntU        (cntU),
        .cntD        (cntD),
        .loadOut     (loadOut),
        .ShrOut      (ShrOut),
        .mem_rd_data (mem_rd_data),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .DoneA       (DoneA),
        .DoneB       (DoneB),
        .down_done   (down_done),
        .Co3         (Co3)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr][15:0];
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rst3 = 0; cnt3 = 0; rst5 = 0; read = 0; write = 0;
        SA = 0; SB = 0; loadA = 0; loadB = 0; ShlA = 0; ShlB = 0;
        cntU = 0; cntD = 0; loadOut = 0; ShrOut = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic load_pair();
        SA = 1; read = 1; tick();
        loadA = 1; SB = 1; read = 1; tick();
        loadB = 1; tick();
    endtask

    task automatic norm_a(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40 && !DoneA; i++) begin
            ShlA = 1; cntU = 1; tick(); cnt++;
        end
    endtask

    task automatic norm_b(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40 && !DoneB; i++) begin
            ShlB = 1; cntU = 1; tick(); cnt++;
        end
    endtask

    task automatic denorm(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40 && !down_done; i++) begin
            ShrOut = 1; cntD = 1; tick(); cnt++;
        end
    endtask

    initial begin
        clr();
        mem_rd_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h0003; mem[1] = 32'h0005;
        mem[2] = 32'hFFFF; mem[3] = 32'hFFFF;
        mem[4] = 32'h0000; mem[5] = 32'h1234;
        mem[8] = 32'hDEADBEEF;
        mem[9] = 32'hDEADBEEF;
        mem[10] = 32'hDEADBEEF;

        rst = 1;
        #12;
        chk("rst_DoneA", 32'(DoneA), 1);
        chk("rst_DoneB", 32'(DoneB), 1);
        chk("rst_down_done", 32'(down_done), 1);
        chk("rst_Co3", 32'(Co3), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        rst = 0;
        @(negedge clk);

        // Pair 0: 3 * 5
        rst3 = 1; rst5 = 1; tick();
        load_pair();
        chk("p0_DoneA_loaded", 32'(DoneA), 0);
        norm_a(n);
        chk("p0_shifts_a", 32'(n), 14);
        norm_b(n);
        chk("p0_shifts_b", 32'(n), 13);
        loadOut = 1; tick();
        chk("p0_res", mem_wr_data, 32'h78000000);
        denorm(n);
        chk("p0_shr", 32'(n), 27);
        chk("p0_res_shifted", mem_wr_data, 32'h0000000F);
        write = 1;
        #1 chk("p0_wr_addr", 32'(mem_addr), 8);
        tick();
        chk("p0_mem8", mem[8], 32'h0000000F);

        // Pair 1: 0xFFFF * 0xFFFF
        cnt3 = 1; rst5 = 1; tick();
        load_pair();
        chk("p1_DoneA", 32'(DoneA), 1);
        chk("p1_DoneB", 32'(DoneB), 1);
        chk("p1_cnt_zero", 32'(down_done), 1);
        loadOut = 1; tick();
        write = 1; tick();
        chk("p1_mem9", mem[9], 32'hFE010000);

        // Pair 2: 0 * 0x1234
        cnt3 = 1; rst5 = 1; tick();
        load_pair();
        norm_a(n);
        chk("p2_shifts_a", 32'(n), 0);
        norm_b(n);
        chk("p2_shifts_b", 32'(n), 3);
        loadOut = 1; tick();
        denorm(n);
        chk("p2_shr", 32'(n), 3);
        write = 1; tick();
        chk("p2_mem10", mem[10], 32'h00000000);

        // Pair counter saturation and address mux
        rst3 = 1; tick();
        chk("pc_clear_Co3", 32'(Co3), 0);
        for (int i = 1; i <= 4; i++) begin
            cnt3 = 1; tick();
            chk($sformatf("pc_Co3_%0d", i), 32'(Co3), (i == 4) ? 1 : 0);
        end
        cnt3 = 1; tick();
        chk("pc_Co3_hold", 32'(Co3), 1);
        rst3 = 1; tick();
        cnt3 = 1; tick();
        cnt3 = 1; tick();
        SA = 1; SB = 1; write = 1;
        #1 chk("addr_SA_prio", 32'(mem_addr), 4);
        SA = 0;
        #1 chk("addr_SB", 32'(mem_addr), 5);
        SB = 0;
        #1 chk("addr_write", 32'(mem_addr), 10);
        write = 0;
        #1 chk("addr_idle", 32'(mem_addr), 0);
        @(negedge clk);

        // Async reset in the middle of a right shift
        for (int i = 0; i < 4; i++) begin cnt3 = 1; tick(); end
        rst3 = 1; rst5 = 1; tick();
        load_pair();
        norm_a(n);
        norm_b(n);
        loadOut = 1; tick();
        ShrOut = 1; cntD = 1; tick();
        for (int i = 0; i < 4; i++) begin cnt3 = 1; tick(); end
        chk("ar_pre_Co3", 32'(Co3), 1);
        ShrOut = 1; cntD = 1;
        #2 rst = 1;
        #1;
        chk("ar_wr_data", mem_wr_data, 0);
        chk("ar_down_done", 32'(down_done), 1);
        chk("ar_Co3", 32'(Co3), 0);
        chk("ar_DoneA", 32'(DoneA), 1);
        chk("ar_wr_en", 32'(mem_wr_en), 0);
        write = 1;
        #1 chk("ar_wr_en_strobe", 32'(mem_wr_en), 1);
        clr();
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Shift counter boundaries
        cntD = 1; ShrOut = 1; tick();
        chk("cnt_no_wrap", 32'(down_done), 1);
        for (int i = 0; i < 35; i++) begin cntU = 1; tick(); end
        for (int i = 0; i < 29; i++) begin cntD = 1; tick(); end
        chk("cnt_sat_29", 32'(down_done), 0);
        cntD = 1; tick();
        chk("cnt_sat_30", 32'(down_done), 1);
        cntU = 1; cntD = 1; rst5 = 1; tick();
        chk("cnt_rst5_prio", 32'(down_done), 1);

        // Load beats shift on the same cycle
        rst3 = 1; tick();
        SA = 1; read = 1; tick();
        loadA = 1; ShlA = 1; tick();
        chk("load_prio", 32'(DoneA), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
